// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit combinational full adder; the serial adder's carry register lives in the parent.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, with start/busy/done handshake and held result.
// Optional macro SERIAL_ADDER_SUB_EN adds a sub port for a-b via inverted B and carry-in of 1.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit added per clock
// DONE  | one-cycle done pulse; start here chains straight into RUN
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] ps;
    logic [WIDTH-1:0] ps_nxt;
    logic [WIDTH-1:0] b_ld;
    logic             c_ld;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             co;
    logic             last;
    logic             load;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_ld = sub ? ~b : b;
    assign c_ld = sub ? 1'b1 : cin;
`else
    assign b_ld = b;
    assign c_ld = cin;
`endif

    assign last = (cnt == CNT_W'(WIDTH - 1));
    assign load = start && ((state == IDLE) || (state == DONE));

    full_adder_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    // New sum bit enters at the MSB so the result lands aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_ps_one
            assign ps_nxt = s;
        end else begin : g_ps_wide
            assign ps_nxt = {s, ps[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            ps    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b_ld;
            ps    <= '0;
            carry <= c_ld;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            ps    <= ps_nxt;
            carry <= co;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                sum  <= ps_nxt;
                cout <= co;
            end
        end
    end

endmodule
